// File: rtl/mdu_iter.sv
// mdu_iter -- iterative multiply/divide unit for the MIPS datapath.
//
// Runs MULTU/DIVU (and, when the SIGNED_OPS_EN macro is defined, MULT/DIV)
// with a radix-2 shift-add multiplier and a restoring divider. Each
// iteration produces one bit. Results land in HI/LO behind a
// start/busy/done handshake.
//
// Configuration macro:
//   SIGNED_OPS_EN  When defined, op[1] selects signed operation. This adds
//                  the sign/magnitude logic and the FIX correction state.
//                  When undefined, op[1] is ignored.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        operation request, sampled only while idle
//   op           00 MULTU, 01 DIVU, 10 MULT, 11 DIV
//   A            multiplicand / dividend
//   B            multiplier / divisor
//   busy         operation in progress
//   done         one-cycle completion pulse
//   hi           product high half / remainder
//   lo           product low half / quotient
//   div_by_zero  valid with done; set when a divide had B == 0

module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

`ifdef SIGNED_OPS_EN
    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
`else
    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
`endif

    state_t state, state_next;

    // Working registers. They are kept apart from hi/lo so that partial
    // results never reach the outputs.
    logic [WIDTH-1:0] work_hi;
    logic [WIDTH-1:0] work_lo;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] a_raw;
    logic [CW-1:0]    cnt;

    // Control strobes decoded by the FSM.
    logic accept;
    logic step;
    logic end_iter;
    logic finish_step;
    logic finish_dbz;

    // Magnitudes of the operands at accept time.
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    // Results of one iteration.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;

`ifdef SIGNED_OPS_EN
    logic               signed_op;
    logic               is_div;
    logic               neg_res;
    logic               neg_rem;
    logic               finish_fix;
    logic [2*WIDTH-1:0] fix_prod;
    logic [WIDTH-1:0]   fix_q;
    logic [WIDTH-1:0]   fix_r;
`else
    logic unused_op_msb;
    assign unused_op_msb = op[1];
`endif

    assign busy = (state != IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and control strobes. A divide with a zero divisor
    // leaves DIV after a single cycle without iterating. At the end of
    // iteration, a signed op goes through FIX. An unsigned op finishes
    // directly from the final iteration's result.
    always_comb begin
        state_next  = state;
        accept      = 1'b0;
        step        = 1'b0;
        end_iter    = 1'b0;
        finish_step = 1'b0;
        finish_dbz  = 1'b0;
`ifdef SIGNED_OPS_EN
        finish_fix  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = op[0] ? DIV : MUL;
                end
            end
            MUL: begin
                step = 1'b1;
                if (cnt == '0) begin
                    end_iter = 1'b1;
                end
            end
            DIV: begin
                if (opb == '0) begin
                    finish_dbz = 1'b1;
                    state_next = IDLE;
                end else begin
                    step = 1'b1;
                    if (cnt == '0) begin
                        end_iter = 1'b1;
                    end
                end
            end
`ifdef SIGNED_OPS_EN
            FIX: begin
                finish_fix = 1'b1;
                state_next = IDLE;
            end
`endif
            default: begin
                state_next = IDLE;
            end
        endcase

        if (end_iter) begin
`ifdef SIGNED_OPS_EN
            if (signed_op) begin
                state_next = FIX;
            end else begin
                state_next  = IDLE;
                finish_step = 1'b1;
            end
`else
            state_next  = IDLE;
            finish_step = 1'b1;
`endif
        end
    end

    // Operand magnitudes. Note that |MIN| = MIN when read as unsigned, and
    // this is the value the unsigned engine needs.
    always_comb begin
`ifdef SIGNED_OPS_EN
        a_mag = (op[1] && A[WIDTH-1]) ? -A : A;
        b_mag = (op[1] && B[WIDTH-1]) ? -B : B;
`else
        a_mag = A;
        b_mag = B;
`endif
    end

    // One iteration of the engine.
    // Multiply: {work_hi,work_lo} is the product register. Its low half
    //   starts as the multiplier. The multiplicand is added into the high
    //   half when the LSB is set, and the register then shifts right.
    // Divide: work_hi is the partial remainder and work_lo shifts the
    //   dividend out while the quotient bits shift in.
    always_comb begin
        mul_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, opb} : '0);
        div_shift = {work_hi, work_lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opb};
        if (state == DIV) begin
            if (!div_diff[WIDTH]) begin
                step_hi = div_diff[WIDTH-1:0];
                step_lo = {work_lo[WIDTH-2:0], 1'b1};
            end else begin
                step_hi = div_shift[WIDTH-1:0];
                step_lo = {work_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], work_lo[WIDTH-1:1]};
        end
    end

`ifdef SIGNED_OPS_EN
    // Sign correction. The product and the quotient are negated when the
    // operand signs differ. The remainder follows the sign of the dividend.
    always_comb begin
        fix_prod = neg_res ? -{work_hi, work_lo} : {work_hi, work_lo};
        fix_q    = neg_res ? -work_lo : work_lo;
        fix_r    = neg_rem ? -work_hi : work_hi;
    end
`endif

    // Datapath and architectural outputs. hi/lo/div_by_zero change only
    // when an operation completes, which is the cycle in which done is
    // raised.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_hi     <= '0;
            work_lo     <= '0;
            opb         <= '0;
            a_raw       <= '0;
            cnt         <= '0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
            done        <= 1'b0;
`ifdef SIGNED_OPS_EN
            signed_op   <= 1'b0;
            is_div      <= 1'b0;
            neg_res     <= 1'b0;
            neg_rem     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;

            if (accept) begin
                a_raw   <= A;
                work_hi <= '0;
                cnt     <= CW'(WIDTH - 1);
                if (op[0]) begin
                    work_lo <= a_mag;
                    opb     <= b_mag;
                end else begin
                    work_lo <= b_mag;
                    opb     <= a_mag;
                end
`ifdef SIGNED_OPS_EN
                signed_op <= op[1];
                is_div    <= op[0];
                neg_res   <= op[1] & (A[WIDTH-1] ^ B[WIDTH-1]);
                neg_rem   <= op[1] & A[WIDTH-1];
`endif
            end

            if (step) begin
                work_hi <= step_hi;
                work_lo <= step_lo;
                cnt     <= cnt - CW'(1);
            end

            if (finish_step) begin
                hi          <= step_hi;
                lo          <= step_lo;
                div_by_zero <= 1'b0;
                done        <= 1'b1;
            end

            if (finish_dbz) begin
                hi          <= a_raw;
                lo          <= '1;
                div_by_zero <= 1'b1;
                done        <= 1'b1;
            end

`ifdef SIGNED_OPS_EN
            if (finish_fix) begin
                if (is_div) begin
                    hi <= fix_r;
                    lo <= fix_q;
                end else begin
                    hi <= fix_prod[2*WIDTH-1:WIDTH];
                    lo <= fix_prod[WIDTH-1:0];
                end
                div_by_zero <= 1'b0;
                done        <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter -- self-checking bench for mdu_iter at WIDTH = 8.
//
// The bench runs directed cases and randomized operations. Expected values
// come from integer arithmetic on the operands: signed or unsigned
// product, truncating division, and a remainder that follows the sign of
// the dividend. Each check goes through checkOutput.

module tb_mdu_iter;

    localparam int W = 8;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   op    = 2'b00;
    logic [W-1:0] a_in  = '0;
    logic [W-1:0] b_in  = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         div_by_zero;

    int n_cmp = 0;
    int n_bad = 0;

    // Architectural values the bench expects hi/lo/div_by_zero to hold.
    logic [W-1:0] prev_hi  = '0;
    logic [W-1:0] prev_lo  = '0;
    logic         prev_dbz = 1'b0;

    mdu_iter #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .A           (a_in),
        .B           (b_in),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    // Counts one comparison and reports it if the values differ.
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Computes the result of one operation with plain integer arithmetic.
    function automatic void refModel(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                     output logic [W-1:0] eh, output logic [W-1:0] el,
                                     output logic ed, output int lat);
        bit     sgn;
        longint sa, sb, p, q, r;
`ifdef SIGNED_OPS_EN
        sgn = o[1];
`else
        sgn = 1'b0;
`endif
        sa = sgn ? longint'($signed(a)) : longint'(a);
        sb = sgn ? longint'($signed(b)) : longint'(b);
        ed = 1'b0;
        if (!o[0]) begin
            p = sa * sb;
            {eh, el} = p[2*W-1:0];
            lat = sgn ? W + 1 : W;
        end else if (b == '0) begin
            eh  = a;
            el  = '1;
            ed  = 1'b1;
            lat = 1;
        end else begin
            q   = sa / sb;
            r   = sa % sb;
            el  = q[W-1:0];
            eh  = r[W-1:0];
            lat = sgn ? W + 1 : W;
        end
    endfunction

    // Issues one operation at the current cycle and follows it to done.
    // glitch >= 0 pulses start with other operands that many cycles after
    // accept. hold keeps start high with unchanged operands while busy.
    // The task returns in the done cycle.
    task automatic applyStimulus(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input int glitch, input bit hold);
        logic [W-1:0] eh, el;
        logic         ed;
        int           lat;
        int           k;
        bit           held_ok;
        refModel(o, a, b, eh, el, ed, lat);
        op    = o;
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) begin
            start = 1'b0;
            op    = 2'($urandom);
            a_in  = W'($urandom);
            b_in  = W'($urandom);
        end
        checkOutput("accept_busy_done", {busy, done}, 2'b10);
        held_ok = 1'b1;
        k = 0;
        while (k < 4 * W) begin
            if (hi !== prev_hi || lo !== prev_lo || div_by_zero !== prev_dbz) held_ok = 1'b0;
            if (glitch >= 0 && k == glitch) begin
                start = 1'b1;
                op    = 2'b00;
                a_in  = W'($urandom);
                b_in  = W'($urandom);
            end else if (glitch >= 0 && k == glitch + 1) begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            k++;
            if (done) break;
        end
        checkOutput("latency", 64'(k), 64'(lat));
        checkOutput("hold_while_busy", held_ok, 1'b1);
        checkOutput("hi", hi, eh);
        checkOutput("lo", lo, el);
        checkOutput("div_by_zero", div_by_zero, ed);
        checkOutput("busy_at_done", busy, 1'b0);
        prev_hi  = eh;
        prev_lo  = el;
        prev_dbz = ed;
    endtask

    // Runs idle cycles. The first of them also confirms that done lasted
    // only one cycle.
    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            checkOutput("idle_busy_done", {busy, done}, 2'b00);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [W-1:0] ra, rb;
        logic [1:0]   ro;
        bit           saw_done;

        // Reset state.
        #2 rst_n = 1'b0;
        #2;
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_done", done, 1'b0);
        checkOutput("reset_hi", hi, '0);
        checkOutput("reset_lo", lo, '0);
        checkOutput("reset_dbz", div_by_zero, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed cases from the test plan.
        applyStimulus(2'b00, 8'd200, 8'd150, -1, 1'b0);
        idleCycles(1);
        applyStimulus(2'b01, 8'd200, 8'd7, -1, 1'b0);
        idleCycles(1);
        applyStimulus(2'b01, 8'h55, 8'h00, -1, 1'b0);
        idleCycles(1);
        applyStimulus(2'b10, 8'hFD, 8'h05, -1, 1'b0);
        idleCycles(1);
        applyStimulus(2'b11, 8'hF9, 8'h02, -1, 1'b0);
        idleCycles(1);
        applyStimulus(2'b11, 8'h80, 8'hFF, -1, 1'b0);
        idleCycles(1);

        // A start pulse during a MULTU must be ignored.
        applyStimulus(2'b00, 8'd13, 8'd17, 2, 1'b0);
        idleCycles(2);

        // start held high through the done cycle issues back to back.
        applyStimulus(2'b00, 8'hFF, 8'hFF, -1, 1'b1);
        applyStimulus(2'b01, 8'hFE, 8'h03, -1, 1'b0);
        idleCycles(1);

        // Reset in the middle of a DIVU aborts it.
        op    = 2'b01;
        a_in  = 8'd200;
        b_in  = 8'd7;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrst_busy", busy, 1'b0);
        checkOutput("midrst_done", done, 1'b0);
        checkOutput("midrst_hi", hi, '0);
        checkOutput("midrst_lo", lo, '0);
        prev_hi  = '0;
        prev_lo  = '0;
        prev_dbz = 1'b0;
        #2 rst_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 2 * W; i++) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1'b1;
        end
        checkOutput("no_done_after_abort", saw_done, 1'b0);
        applyStimulus(2'b00, 8'd9, 8'd11, -1, 1'b0);
        idleCycles(1);

        // Randomized operations with edge-biased operands.
        for (int n = 0; n < 60; n++) begin
            ro = 2'($urandom_range(0, 3));
            ra = ($urandom_range(0, 7) == 0) ? 8'h80 : W'($urandom);
            case ($urandom_range(0, 7))
                0:       rb = 8'h00;
                1:       rb = 8'hFF;
                2:       rb = 8'h01;
                default: rb = W'($urandom);
            endcase
            applyStimulus(ro, ra, rb, -1, 1'b0);
            idleCycles($urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
